// File: rtl/pattern_serializer.sv
// Serializes one decoded UART command: shifts a pattern out LSB first, each bit
// held for a fast or slow period chosen by its frequency bit, one-shot or continuous.
module pattern_serializer #(
   parameter int DATA_BIT  = 16,
   parameter int FAST_DIV  = 10,
   parameter int SLOW_DIV  = 20,
   parameter int DIV_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load,
   input  logic [DATA_BIT-1:0] i_output_pattern,
   input  logic [DATA_BIT-1:0] i_freq_pattern,
   input  logic                i_mode,
   input  logic                i_start,
   input  logic                i_stop,
   output logic                o_serial,
   output logic                o_busy,
   output logic                o_bit_tick,
   output logic                o_done_tick
);

   localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DATA_BIT - 1);
   localparam logic [DIV_WIDTH-1:0] FAST_LOAD = DIV_WIDTH'(FAST_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] SLOW_LOAD = DIV_WIDTH'(SLOW_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state, state_nx;
   logic [DATA_BIT-1:0]  pend_pattern, pend_pattern_nx;
   logic [DATA_BIT-1:0]  pend_freq, pend_freq_nx;
   logic                 pend_mode, pend_mode_nx;
   logic [DATA_BIT-1:0]  work_pattern, work_pattern_nx;
   logic [DATA_BIT-1:0]  work_freq, work_freq_nx;
   logic                 work_mode, work_mode_nx;
   logic [IDX_W-1:0]     index, index_nx;
   logic [DIV_WIDTH-1:0] counter, counter_nx;
   logic                 done_pending, done_pending_nx;

   function automatic logic [DIV_WIDTH-1:0] period_load(input logic fast);
      return fast ? FAST_LOAD : SLOW_LOAD;
   endfunction

   // Next-state logic; outputs are later registered from these next values so
   // they line up with the state they describe without any input-to-output path.
   always_comb begin
      state_nx        = state;
      pend_pattern_nx = pend_pattern;
      pend_freq_nx    = pend_freq;
      pend_mode_nx    = pend_mode;
      work_pattern_nx = work_pattern;
      work_freq_nx    = work_freq;
      work_mode_nx    = work_mode;
      index_nx        = index;
      counter_nx      = counter;
      done_pending_nx = 1'b0;

      if (i_load) begin
         pend_pattern_nx = i_output_pattern;
         pend_freq_nx    = i_freq_pattern;
         pend_mode_nx    = i_mode;
      end

      case (state)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               // A load in the same cycle as start feeds the new pass directly.
               if (i_load) begin
                  work_pattern_nx = i_output_pattern;
                  work_freq_nx    = i_freq_pattern;
                  work_mode_nx    = i_mode;
               end else begin
                  work_pattern_nx = pend_pattern;
                  work_freq_nx    = pend_freq;
                  work_mode_nx    = pend_mode;
               end
               index_nx   = '0;
               counter_nx = period_load(work_freq_nx[0]);
               state_nx   = S_RUN;
            end
         end

         S_RUN: begin
            if (i_stop) begin
               state_nx = S_IDLE;
            end else if (counter == '0) begin
               if (index != LAST_IDX) begin
                  index_nx   = index + 1'b1;
                  counter_nx = period_load(work_freq[index_nx]);
               end else if (!work_mode) begin
                  state_nx = S_DONE;
               end else begin
                  work_pattern_nx = pend_pattern;
                  work_freq_nx    = pend_freq;
                  work_mode_nx    = pend_mode;
                  index_nx        = '0;
                  counter_nx      = period_load(pend_freq[0]);
                  done_pending_nx = 1'b1;
               end
            end else begin
               counter_nx = counter - 1'b1;
            end
         end

         S_DONE: begin
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pend_pattern <= '0;
         pend_freq    <= '0;
         pend_mode    <= 1'b0;
         work_pattern <= '0;
         work_freq    <= '0;
         work_mode    <= 1'b0;
         index        <= '0;
         counter      <= '0;
         done_pending <= 1'b0;
         o_serial     <= 1'b0;
         o_busy       <= 1'b0;
         o_bit_tick   <= 1'b0;
         o_done_tick  <= 1'b0;
      end else begin
         state        <= state_nx;
         pend_pattern <= pend_pattern_nx;
         pend_freq    <= pend_freq_nx;
         pend_mode    <= pend_mode_nx;
         work_pattern <= work_pattern_nx;
         work_freq    <= work_freq_nx;
         work_mode    <= work_mode_nx;
         index        <= index_nx;
         counter      <= counter_nx;
         done_pending <= done_pending_nx;
         o_serial     <= (state_nx == S_RUN) ? work_pattern_nx[index_nx] : 1'b0;
         o_busy       <= (state_nx != S_IDLE);
         o_bit_tick   <= (state_nx == S_RUN) && (counter_nx == '0);
         o_done_tick  <= (state_nx == S_DONE) || done_pending_nx;
      end
   end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: one instance at FAST=2/SLOW=4 and a
// second at FAST=1/SLOW=2 to cover single-cycle bit periods.
module tb_pattern_serializer;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] out_pattern;
   logic [15:0] freq_pattern;
   logic        mode;
   logic        start;
   logic        stop;
   logic        serial, busy, bit_tick, done_tick;
   logic        serial1, busy1, bit_tick1, done_tick1;

   int check_count = 0;
   int error_count = 0;

   pattern_serializer #(
      .DATA_BIT(16), .FAST_DIV(2), .SLOW_DIV(4), .DIV_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_load(load),
      .i_output_pattern(out_pattern), .i_freq_pattern(freq_pattern),
      .i_mode(mode), .i_start(start), .i_stop(stop),
      .o_serial(serial), .o_busy(busy), .o_bit_tick(bit_tick), .o_done_tick(done_tick)
   );

   pattern_serializer #(
      .DATA_BIT(16), .FAST_DIV(1), .SLOW_DIV(2), .DIV_WIDTH(8)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .i_load(load),
      .i_output_pattern(out_pattern), .i_freq_pattern(freq_pattern),
      .i_mode(mode), .i_start(start), .i_stop(stop),
      .o_serial(serial1), .o_busy(busy1), .o_bit_tick(bit_tick1), .o_done_tick(done_tick1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of inputs; pulses are dropped again after the sampling edge.
   task automatic applyStimulus(input bit ld, input logic [15:0] pat, input logic [15:0] fr,
                                input bit md, input bit st, input bit sp);
      load         = ld;
      out_pattern  = pat;
      freq_pattern = fr;
      mode         = md;
      start        = st;
      stop         = sp;
      step();
      load  = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   function automatic logic [3:0] observe(input bit which);
      return which ? {busy1, serial1, bit_tick1, done_tick1} : {busy, serial, bit_tick, done_tick};
   endfunction

   // Walks a whole pass cycle by cycle against {busy, serial, bit_tick, done_tick},
   // optionally injecting a load and/or start at the first cycle of one bit.
   task automatic checkPass(input string tag, input bit which, input logic [15:0] pat,
                            input logic [15:0] fr, input bit first_done,
                            input int fast_div, input int slow_div, input int inject_bit,
                            input bit inj_load, input bit inj_start,
                            input logic [15:0] inj_pat, input logic [15:0] inj_fr, input bit inj_mode);
      logic [3:0] expected;
      int div;
      for (int k = 0; k < 16; k++) begin
         div = fr[k] ? fast_div : slow_div;
         for (int c = 0; c < div; c++) begin
            expected = {1'b1, pat[k], (c == div - 1), (first_done && k == 0 && c == 0)};
            checkOutput($sformatf("%s_b%0d_c%0d", tag, k, c), 32'(observe(which)), 32'(expected));
            if (k == inject_bit && c == 0) begin
               load  = inj_load;
               start = inj_start;
               if (inj_load) begin
                  out_pattern  = inj_pat;
                  freq_pattern = inj_fr;
                  mode         = inj_mode;
               end
            end
            step();
            load  = 1'b0;
            start = 1'b0;
         end
      end
   endtask

   task automatic checkEnd(input string tag, input bit which);
      checkOutput({tag, "_done"}, 32'(observe(which)), 32'h9);
      step();
      checkOutput({tag, "_idle"}, 32'(observe(which)), 32'h0);
   endtask

   initial begin
      rst_n        = 1'b0;
      load         = 1'b0;
      out_pattern  = '0;
      freq_pattern = '0;
      mode         = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      step();
      checkOutput("reset_outputs", 32'(observe(0)), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("after_reset_idle", 32'(observe(0)), 32'h0);

      // All-fast, all-slow and mixed one-shot passes of A5A5.
      applyStimulus(1, 16'hA5A5, 16'hFFFF, 0, 0, 0);
      checkOutput("load_only_idle", 32'(observe(0)), 32'h0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      checkPass("fast", 0, 16'hA5A5, 16'hFFFF, 0, 2, 4, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("fast", 0);

      applyStimulus(1, 16'hA5A5, 16'h0000, 0, 0, 0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      checkPass("slow", 0, 16'hA5A5, 16'h0000, 0, 2, 4, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("slow", 0);

      applyStimulus(1, 16'hA5A5, 16'h00FF, 0, 0, 0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      checkPass("mixed", 0, 16'hA5A5, 16'h00FF, 0, 2, 4, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("mixed", 0);

      // Continuous: reloads during a pass only take effect at the next wrap.
      applyStimulus(1, 16'h0001, 16'hFFFF, 1, 0, 0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      checkPass("cont_p1", 0, 16'h0001, 16'hFFFF, 0, 2, 4, 2, 1, 0, 16'h8000, 16'hFFFF, 1);
      checkPass("cont_p2", 0, 16'h8000, 16'hFFFF, 1, 2, 4, 2, 1, 0, 16'h0003, 16'hFFFF, 0);
      checkPass("cont_p3", 0, 16'h0003, 16'hFFFF, 1, 2, 4, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("cont_p3", 0);

      // Stop at bit 5, then simultaneous start and stop in idle.
      applyStimulus(1, 16'hA5A5, 16'hFFFF, 0, 0, 0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step();
      checkOutput("stop_at_bit5", 32'(observe(0)), 32'hC);
      applyStimulus(0, 16'h0, 16'h0, 0, 0, 1);
      checkOutput("stopped", 32'(observe(0)), 32'h0);
      step();
      checkOutput("stopped_no_done", 32'(observe(0)), 32'h0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 1);
      checkOutput("start_stop_idle", 32'(observe(0)), 32'h0);
      step();
      checkOutput("start_stop_idle2", 32'(observe(0)), 32'h0);

      // Load bypass on start, and a start during the run is ignored.
      applyStimulus(1, 16'h00FF, 16'hFFFF, 0, 1, 0);
      checkPass("bypass", 0, 16'h00FF, 16'hFFFF, 0, 2, 4, 3, 0, 1, 16'h0, 16'h0, 0);
      checkEnd("bypass", 0);

      // Reset mid-pass, then a pass from the cleared pending registers.
      applyStimulus(1, 16'hA5A5, 16'hFFFF, 0, 1, 0);
      for (int i = 0; i < 5; i++) step();
      checkOutput("pre_reset_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_pass", 32'(observe(0)), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("reset_release_idle", 32'(observe(0)), 32'h0);
      applyStimulus(0, 16'h0, 16'h0, 0, 1, 0);
      checkPass("zeros", 0, 16'h0000, 16'h0000, 0, 2, 4, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("zeros", 0);

      // Single-cycle fast bits on the second instance.
      applyStimulus(0, 16'h0, 16'h0, 0, 0, 1);
      checkOutput("div1_idle", 32'(observe(1)), 32'h0);
      applyStimulus(1, 16'h0005, 16'hFF0F, 0, 1, 0);
      checkPass("div1", 1, 16'h0005, 16'hFF0F, 0, 1, 2, -1, 0, 0, 16'h0, 16'h0, 0);
      checkEnd("div1", 1);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Drives the serial output line from one decoded UART command. Sits directly downstream of the UART packet decoder. It takes an output pattern, a per-bit frequency pattern, a mode bit and start/stop controls, and shifts the pattern out one bit at a time. Each bit is held for a fast or slow number of clock cycles, selected by the matching frequency-pattern bit. Mode selects a single pass (one-shot) or continuous repetition.

## Interface
- DATA_BIT, 16: width of the output and frequency patterns (bits per pass).
- FAST_DIV, 10: clock cycles per bit when the frequency bit = 1; must be ≥ 1.
- SLOW_DIV, 20: clock cycles per bit when the frequency bit = 0; must be ≥ 1.
- DIV_WIDTH, 8: bit-period counter width; must hold max(FAST_DIV, SLOW_DIV) − 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_load  in  1  one-cycle pulse; captures the pattern, frequency pattern and mode into the pending registers (driven by the decoder done tick).
- i_output_pattern  in  DATA_BIT  bit values to serialize.
- i_freq_pattern  in  DATA_BIT  per-bit speed select, 1 = fast, 0 = slow.
- i_mode  in  1  0 = one-shot, 1 = continuous.
- i_start  in  1  one-cycle start pulse.
- i_stop  in  1  stop request, level or pulse.
- o_serial  out  1  serial line; idle level 0.
- o_busy  out  1  high while state ≠ S_IDLE.
- o_bit_tick  out  1  high in the last cycle of every bit period.
- o_done_tick  out  1  one-cycle pass-complete pulse.

## Operation
- **Pending registers** (pattern, frequency, mode):
  - Written on i_load in any state.
  - Copied into the working registers at each pass start: on start from idle, and at the wrap in continuous mode.
  - A load during a pass never alters the bit currently being sent.
- **S_IDLE:**
  - o_serial = 0.
  - On i_start with i_stop low: copy pending → working. If i_load occurs in the same cycle, the incoming port values bypass the pending registers and are used directly.
  - Then set bit index = 0, load the counter with the period of bit 0, and go to S_RUN.
- **S_RUN:**
  - o_serial = working_pattern[index], sent LSB first.
  - The counter counts down from DIV − 1 to 0, where DIV = FAST_DIV if working_freq[index] = 1, else SLOW_DIV.
  - When the counter = 0: assert o_bit_tick.
    - If index < DATA_BIT − 1: index + 1, reload the counter with the next bit's period.
    - If index = DATA_BIT − 1 and working mode = 0: go to S_DONE.
    - If index = DATA_BIT − 1 and working mode = 1: copy pending → working, index = 0, stay in S_RUN, set done_pending. o_done_tick is then high in the first cycle of the new pass.
- **S_DONE:**
  - o_done_tick = 1, o_serial = 0, lasts one cycle, then S_IDLE.
- **Stop:**
  - i_stop in S_RUN or S_DONE: the next state is S_IDLE and o_serial = 0 from the next cycle. No o_done_tick is issued and done_pending is cleared.
  - i_stop and i_start in the same cycle in idle: stop wins, the block stays idle.
- i_start while in S_RUN or S_DONE is ignored.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Timing
- **Reset:** state S_IDLE; o_serial, o_busy, o_bit_tick and o_done_tick = 0; pending, working, index and counter registers = 0. Reset mid-pass aborts immediately and emits no done tick.
- **Start latency:** i_start sampled at edge N → o_busy = 1 and o_serial = bit 0 from cycle N + 1.
- **Bit period:** bit k occupies exactly DIV(k) cycles, with no gap cycles between bits or between passes in continuous mode.
- **One-shot pass length:** Σ DIV(k) cycles of S_RUN, followed by 1 cycle of S_DONE. o_busy falls the cycle after S_DONE.
- A new i_start is accepted in the first S_IDLE cycle after S_DONE.
- **Period 1 (FAST_DIV or SLOW_DIV = 1):** the bit lasts one cycle and o_bit_tick is high in that cycle.

## Test plan
1. DATA_BIT = 16, FAST_DIV = 2, SLOW_DIV = 4. Load 16'hA5A5 with freq 16'hFFFF, mode 0, then start.
   - o_serial = 1,0,1,0,0,1,0,1,… with each bit lasting 2 cycles.
   - 32 busy cycles in S_RUN, 16 bit ticks, then o_done_tick for 1 cycle, then idle.
2. Same pattern with freq 16'h0000 → each bit lasts 4 cycles, 64 cycles in S_RUN. Freq 16'h00FF → bits 0–7 last 2 cycles and bits 8–15 last 4 cycles, 48 cycles total.
3. Continuous mode with 16'h0001 / freq 16'hFFFF. During pass 1, load 16'h8000.
   - Pass 1 is unchanged.
   - Pass 2 begins with no gap and sends the new pattern.
   - o_done_tick fires in the first cycle of pass 2.
4. Stop at bit 5 of a pass → o_serial = 0 and o_busy = 0 on the next cycle, with no o_done_tick. i_start and i_stop together in idle → the block remains idle.
5. i_load and i_start in the same idle cycle with 16'h00FF → the first bits are 1s (bypass). i_start during S_RUN → ignored and the pass completes normally.
6. Assert rst_n mid-pass → all outputs 0 immediately. After release, start with the pending registers at reset value → 16 zeros on o_serial.
